// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared register-file constants for the core
// Purpose: register count, register address width, x0 constant and the
//          width of the in-flight write total, shared by the scoreboard,
//          its interface and the per-register counters.
// Ports:   none (package)
package core_pkg;

    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int INFLIGHT_W = 6;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_X0 = '0;

endpackage

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - ID/WB handshake bundle for the register scoreboard
// Purpose: groups the lock (ID), unlock (WB), source query, flush and status
//          signals of the register scoreboard.
// Ports:   none; modport master = pipeline side (drives *_i),
//          modport slave = scoreboard side (drives *_o).
interface reg_scoreboard_if;
    import core_pkg::*;

    logic                  lock_valid_i;
    reg_addr_t             lock_rd_i;
    logic                  lock_ready_o;
    logic                  unlock_valid_i;
    reg_addr_t             unlock_rd_i;
    reg_addr_t             rs1_i;
    reg_addr_t             rs2_i;
    logic                  stall_o;
    logic                  flush_i;
    logic [INFLIGHT_W-1:0] inflight_o;
    logic                  err_o;

    modport master (
        output lock_valid_i, lock_rd_i, unlock_valid_i, unlock_rd_i,
               rs1_i, rs2_i, flush_i,
        input  lock_ready_o, stall_o, inflight_o, err_o
    );

    modport slave (
        input  lock_valid_i, lock_rd_i, unlock_valid_i, unlock_rd_i,
               rs1_i, rs2_i, flush_i,
        output lock_ready_o, stall_o, inflight_o, err_o
    );

endinterface

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - saturating pending-write counter for one register
// Purpose: counts outstanding writes to one architectural register.
// Ports:   clk, rst     - clock, asynchronous active-high reset
//          inc          - a lock of this register is accepted this cycle
//          dec          - an unlock of this register arrives this cycle
//          clr          - flush: clear the count (wins over inc/dec)
//          count        - current pending-write count
//          full         - count is at its maximum
//          nonzero      - count is above zero
module sb_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         full,
    output logic         nonzero
);

    assign full    = &count;
    assign nonzero = |count;

    // inc and dec together cancel; neither end of the range ever wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + W'(1);
        end else if (dec && !inc && nonzero) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register scoreboard tracking pending writes per register
// Purpose: ID locks a destination register, WB unlocks it on retirement;
//          stalls the ID instruction while a source (or a saturated
//          destination) has writes pending. x0 is never tracked.
// Ports:   clk    - clock, rising edge
//          rst_i  - asynchronous active-high reset
//          sb     - reg_scoreboard_if.slave: lock/unlock handshakes, rs1/rs2
//                   query, flush, stall_o, inflight_o, sticky err_o
// Config:  SCOREBOARD_BYPASS_EN - a source whose last pending write retires
//          in the same cycle does not stall (WB-to-ID forwarding).
module reg_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREGS = core_pkg::NREGS
) (
    input  logic               clk,
    input  logic               rst_i,
    reg_scoreboard_if.slave    sb
);
    import core_pkg::*;

    logic [CNT_W-1:0]      cnt  [NREGS];
    logic                  full [NREGS];
    logic                  nz   [NREGS];

    logic                  lock_ready;
    logic                  lock_fire;
    logic                  unlock_act;
    logic                  same_rd;
    logic                  up;
    logic                  down;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic [INFLIGHT_W-1:0] inflight_q;
    logic                  err_q;

    // x0 is a constant zero entry so lookups by any address stay uniform.
    assign cnt[0]  = '0;
    assign full[0] = 1'b0;
    assign nz[0]   = 1'b0;

    // A saturated destination can still be locked when its own unlock
    // arrives in the same cycle: the pair cancels and the count holds.
    assign lock_ready = (sb.lock_rd_i == REG_X0) || !full[sb.lock_rd_i] ||
                        (sb.unlock_valid_i && (sb.unlock_rd_i == sb.lock_rd_i));

    // Flush discards whatever lock or unlock coincides with it.
    assign lock_fire  = sb.lock_valid_i && lock_ready &&
                        (sb.lock_rd_i != REG_X0) && !sb.flush_i;
    assign unlock_act = sb.unlock_valid_i && (sb.unlock_rd_i != REG_X0) && !sb.flush_i;

    generate
        for (genvar r = 1; r < NREGS; r++) begin : g_reg
            logic inc;
            logic dec;

            assign inc = lock_fire  && (sb.lock_rd_i   == reg_addr_t'(r));
            assign dec = unlock_act && (sb.unlock_rd_i == reg_addr_t'(r));

            sb_counter #(.W(CNT_W)) u_cnt (
                .clk     (clk),
                .rst     (rst_i),
                .inc     (inc),
                .dec     (dec),
                .clr     (sb.flush_i),
                .count   (cnt[r]),
                .full    (full[r]),
                .nonzero (nz[r])
            );
        end
    endgenerate

    // The running total mirrors exactly what the counters will do at the edge.
    assign same_rd = lock_fire && unlock_act && (sb.lock_rd_i == sb.unlock_rd_i);
    assign up      = lock_fire && !same_rd;
    assign down    = unlock_act && !same_rd && nz[sb.unlock_rd_i];

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (sb.flush_i) begin
                inflight_q <= '0;
            end else begin
                inflight_q <= inflight_q + INFLIGHT_W'(up) - INFLIGHT_W'(down);
            end
            if (unlock_act && (cnt[sb.unlock_rd_i] == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rs1_busy = nz[sb.rs1_i];
        rs2_busy = nz[sb.rs2_i];
`ifdef SCOREBOARD_BYPASS_EN
        if (unlock_act && (sb.unlock_rd_i == sb.rs1_i) && (cnt[sb.rs1_i] == CNT_W'(1))) begin
            rs1_busy = 1'b0;
        end
        if (unlock_act && (sb.unlock_rd_i == sb.rs2_i) && (cnt[sb.rs2_i] == CNT_W'(1))) begin
            rs2_busy = 1'b0;
        end
`else
`endif
    end

    assign sb.lock_ready_o = lock_ready;
    assign sb.stall_o      = rs1_busy || rs2_busy || (sb.lock_valid_i && !lock_ready);
    assign sb.inflight_o   = inflight_q;
    assign sb.err_o        = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - scoreboard-checked directed bench for reg_scoreboard
module tb_reg_scoreboard;

`ifdef SCOREBOARD_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct {
        string      name;
        logic       rdy;
        logic       stall;
        logic [5:0] infl;
        logic       err;
    } exp_t;

    logic clk;
    logic rst_i;
    int   total;
    int   bad;
    exp_t q[$];

    reg_scoreboard_if sb_if ();

    reg_scoreboard dut (
        .clk   (clk),
        .rst_i (rst_i),
        .sb    (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string n, input string f, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%0d required=%0d", n, f, act, req);
        end
    endtask

    // Monitor: one expectation is consumed per cycle, mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.name, "lock_ready", {7'd0, sb_if.lock_ready_o}, {7'd0, e.rdy});
            check(e.name, "stall",      {7'd0, sb_if.stall_o},      {7'd0, e.stall});
            check(e.name, "inflight",   {2'd0, sb_if.inflight_o},   {2'd0, e.infl});
            check(e.name, "err",        {7'd0, sb_if.err_o},        {7'd0, e.err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lv, input logic [4:0] lrd, input logic uv,
                         input logic [4:0] urd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic fl);
        sb_if.lock_valid_i   = lv;
        sb_if.lock_rd_i      = lrd;
        sb_if.unlock_valid_i = uv;
        sb_if.unlock_rd_i    = urd;
        sb_if.rs1_i          = r1;
        sb_if.rs2_i          = r2;
        sb_if.flush_i        = fl;
    endtask

    task automatic chk(input string n, input logic rdy, input logic stall,
                       input logic [5:0] infl, input logic err);
        exp_t e;
        e.name  = n;
        e.rdy   = rdy;
        e.stall = stall;
        e.infl  = infl;
        e.err   = err;
        q.push_back(e);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("in_reset", 1, 0, 0, 0);
        tick();
        tick();
        rst_i = 1'b0;

        drive(1, 5, 0, 0, 0, 0, 0);  chk("lock5", 1, 0, 0, 0);         tick();
        drive(0, 0, 0, 0, 5, 0, 0);  chk("rs1_5", 1, 1, 1, 0);         tick();
        drive(0, 0, 1, 5, 5, 0, 0);  chk("unlock5", 1, !BYP, 1, 0);    tick();
        drive(0, 0, 0, 0, 5, 0, 0);  chk("free5", 1, 0, 0, 0);         tick();

        for (int k = 0; k < 3; k++) begin
            drive(1, 7, 0, 0, 0, 0, 0);
            chk("lock7", 1, 0, 6'(k), 0);
            tick();
        end
        drive(1, 7, 0, 0, 0, 0, 0);  chk("full7", 0, 1, 3, 0);         tick();
        drive(1, 7, 1, 7, 0, 0, 0);  chk("lock_unlock7", 1, 0, 3, 0);  tick();
        drive(0, 0, 0, 0, 0, 7, 0);  chk("hold7", 1, 1, 3, 0);         tick();

        drive(1, 0, 0, 0, 0, 0, 0);  chk("x0_lock", 1, 0, 3, 0);       tick();
        drive(0, 0, 1, 9, 0, 0, 0);  chk("unlock9", 1, 0, 3, 0);       tick();
        drive(0, 0, 0, 0, 9, 0, 0);  chk("err9", 1, 0, 3, 1);          tick();

        drive(1, 3, 0, 0, 0, 0, 0);  chk("lock3", 1, 0, 3, 1);         tick();
        drive(1, 4, 0, 0, 0, 0, 0);  chk("lock4", 1, 0, 4, 1);         tick();
        drive(1, 6, 0, 0, 0, 0, 1);  chk("flush", 1, 0, 5, 1);         tick();
        drive(0, 0, 0, 0, 3, 4, 0);  chk("post_flush", 1, 0, 0, 1);    tick();
        drive(0, 0, 0, 0, 6, 7, 0);  chk("no6_no7", 1, 0, 0, 1);       tick();

        drive(1, 10, 0, 0, 0, 0, 0); chk("lock10", 1, 0, 0, 1);        tick();
        drive(0, 0, 1, 10, 0, 10, 0); chk("bypass10", 1, !BYP, 1, 1);  tick();
        drive(0, 0, 0, 0, 0, 10, 0); chk("free10", 1, 0, 0, 1);        tick();

        drive(1, 12, 0, 0, 0, 0, 0); chk("lock12", 1, 0, 0, 1);        tick();
        drive(0, 0, 0, 0, 12, 0, 0); chk("pend12", 1, 1, 1, 1);        tick();
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 12, 0, 0); chk("async_rst", 1, 0, 0, 0);     tick();
        rst_i = 1'b0;
        drive(1, 12, 0, 0, 0, 0, 0); chk("relock12", 1, 0, 0, 0);      tick();
        drive(0, 0, 0, 0, 12, 0, 0); chk("after_rst", 1, 1, 1, 0);     tick();
        drive(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
